// File: rtl/comm_master.sv
// UART command master: sends a 3-byte 8N1 frame {cmd, data_hi, data_lo} and waits for a 1-byte reply.
// Optional response timeout is compiled in with `define COMM_MASTER_TMO_EN.
module comm_master #(
   parameter int BAUD_DIV = 2604,
   parameter int RESP_TMO = 5000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        snd_cmd,
   input  logic [7:0]  cmd,
   input  logic [15:0] data,
   output logic        TX,
   input  logic        RX,
   output logic        busy,
   output logic [7:0]  resp,
   output logic        resp_rdy,
   output logic        cmd_cmplt,
   output logic        tmo
);

   localparam int CNT_W = $clog2(BAUD_DIV);
   localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] SND_CMD   = 3'd1;
   localparam logic [2:0] SND_HI    = 3'd2;
   localparam logic [2:0] SND_LO    = 3'd3;
   localparam logic [2:0] WAIT_RESP = 3'd4;

   logic [2:0]       r_state;
   logic [23:0]      r_buf;
   logic [CNT_W-1:0] r_txBaud;
   logic [3:0]       r_txBit;
   logic             r_tx;
   logic [7:0]       r_resp;
   logic             r_respRdy;
   logic             r_cmdCmplt;
   logic             r_tmo;

   logic [1:0]       r_rxSync;
   logic             r_rxPrev;
   logic             r_rxActive;
   logic [CNT_W-1:0] r_rxBaud;
   logic [3:0]       r_rxBit;
   logic [7:0]       r_rxData;

   logic [7:0] w_curByte;
   logic       w_txBitEnd;
   logic       w_rxIn;
   logic       w_rxFall;
   logic       w_rxSample;
   logic       w_rxValid;
   logic       w_tmoHit;

   always_comb begin
      w_curByte = r_buf[7:0];
      case (r_state)
         SND_CMD: w_curByte = r_buf[23:16];
         SND_HI:  w_curByte = r_buf[15:8];
         default: w_curByte = r_buf[7:0];
      endcase
   end

   assign w_txBitEnd = (r_txBaud == BAUD_LAST);

   // Receiver bit index: 0 = start-bit recheck at half period, 1..8 = data, 9 = stop.
   assign w_rxIn     = r_rxSync[1];
   assign w_rxFall   = r_rxPrev & ~w_rxIn;
   assign w_rxSample = r_rxActive &&
                       (((r_rxBit == 4'd0) && (r_rxBaud == HALF_LAST)) ||
                        ((r_rxBit != 4'd0) && (r_rxBaud == BAUD_LAST)));
   assign w_rxValid  = w_rxSample && (r_rxBit == 4'd9) && w_rxIn;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rxSync   <= 2'b11;
         r_rxPrev   <= 1'b1;
         r_rxActive <= 1'b0;
         r_rxBaud   <= '0;
         r_rxBit    <= 4'd0;
         r_rxData   <= 8'h00;
      end else begin
         r_rxSync <= {r_rxSync[0], RX};
         r_rxPrev <= w_rxIn;
         if (!r_rxActive) begin
            if (w_rxFall) begin
               r_rxActive <= 1'b1;
               r_rxBaud   <= '0;
               r_rxBit    <= 4'd0;
            end
         end else if (w_rxSample) begin
            r_rxBaud <= '0;
            if (r_rxBit == 4'd0) begin
               if (w_rxIn) begin
                  r_rxActive <= 1'b0;
               end else begin
                  r_rxBit <= 4'd1;
               end
            end else if (r_rxBit == 4'd9) begin
               r_rxActive <= 1'b0;
            end else begin
               r_rxData <= {w_rxIn, r_rxData[7:1]};
               r_rxBit  <= r_rxBit + 4'd1;
            end
         end else begin
            r_rxBaud <= r_rxBaud + 1'b1;
         end
      end
   end

`ifdef COMM_MASTER_TMO_EN
   localparam int TMO_W = $clog2(RESP_TMO + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(RESP_TMO - 1);

   logic [TMO_W-1:0] r_tmoCnt;

   always_ff @(posedge clk) begin
      if (rst || (r_state != WAIT_RESP)) begin
         r_tmoCnt <= '0;
      end else begin
         r_tmoCnt <= r_tmoCnt + 1'b1;
      end
   end

   assign w_tmoHit = (r_state == WAIT_RESP) && (r_tmoCnt == TMO_LAST);
`else
   // Never true; keeps RESP_TMO referenced in builds without the timeout.
   assign w_tmoHit = (RESP_TMO < 0);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_buf      <= 24'h000000;
         r_txBaud   <= '0;
         r_txBit    <= 4'd0;
         r_tx       <= 1'b1;
         r_resp     <= 8'h00;
         r_respRdy  <= 1'b0;
         r_cmdCmplt <= 1'b0;
         r_tmo      <= 1'b0;
      end else begin
         r_respRdy <= 1'b0;
         r_tmo     <= 1'b0;
         case (r_state)
            IDLE: begin
               if (snd_cmd) begin
                  r_buf      <= {cmd, data};
                  r_cmdCmplt <= 1'b0;
                  r_tx       <= 1'b0;
                  r_txBaud   <= '0;
                  r_txBit    <= 4'd0;
                  r_state    <= SND_CMD;
               end
            end
            SND_CMD, SND_HI, SND_LO: begin
               if (w_txBitEnd) begin
                  r_txBaud <= '0;
                  if (r_txBit == 4'd9) begin
                     r_txBit <= 4'd0;
                     case (r_state)
                        SND_CMD: begin r_tx <= 1'b0; r_state <= SND_HI;    end
                        SND_HI:  begin r_tx <= 1'b0; r_state <= SND_LO;    end
                        default: begin r_tx <= 1'b1; r_state <= WAIT_RESP; end
                     endcase
                  end else begin
                     r_tx    <= (r_txBit == 4'd8) ? 1'b1 : w_curByte[r_txBit[2:0]];
                     r_txBit <= r_txBit + 4'd1;
                  end
               end else begin
                  r_txBaud <= r_txBaud + 1'b1;
               end
            end
            WAIT_RESP: begin
               // A valid byte wins over a timeout landing in the same cycle.
               if (w_rxValid) begin
                  r_resp     <= r_rxData;
                  r_respRdy  <= 1'b1;
                  r_cmdCmplt <= 1'b1;
                  r_state    <= IDLE;
               end else if (w_tmoHit) begin
                  r_tmo   <= 1'b1;
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign TX        = r_tx;
   assign busy      = (r_state != IDLE);
   assign resp      = r_resp;
   assign resp_rdy  = r_respRdy;
   assign cmd_cmplt = r_cmdCmplt;
   assign tmo       = r_tmo;

endmodule

// File: tb/tb_comm_master.sv
// Self-checking bench for comm_master: frames checked bit-by-bit against a UART model, replies looped back on RX.
module tb_comm_master;

   localparam int BD    = 16;
   localparam int TMO   = 2000;
   localparam int FRAME = 30 * BD;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        snd_cmd = 1'b0;
   logic [7:0]  cmd = 8'h00;
   logic [15:0] data = 16'h0000;
   logic        RX = 1'b1;
   logic        TX;
   logic        busy;
   logic [7:0]  resp;
   logic        resp_rdy;
   logic        cmd_cmplt;
   logic        tmo;

   int testsRun = 0;
   int testsFailed = 0;
   int rdyPulses = 0;
   int tmoPulses = 0;
   logic [7:0] expResp = 8'h00;

   comm_master #(.BAUD_DIV(BD), .RESP_TMO(TMO)) dut (
      .clk(clk), .rst(rst), .snd_cmd(snd_cmd), .cmd(cmd), .data(data),
      .TX(TX), .RX(RX), .busy(busy), .resp(resp), .resp_rdy(resp_rdy),
      .cmd_cmplt(cmd_cmplt), .tmo(tmo)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (resp_rdy === 1'b1) rdyPulses <= rdyPulses + 1;
      if (tmo === 1'b1) tmoPulses <= tmoPulses + 1;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic sendCmd(input logic [7:0] c, input logic [15:0] d);
      cmd = c;
      data = d;
      snd_cmd = 1'b1;
      tick(1);
      snd_cmd = 1'b0;
      cmd = 8'($urandom);
      data = 16'($urandom);
   endtask

   task automatic sendRx(input logic [7:0] b, input logic stopBit);
      RX = 1'b0;
      tick(BD);
      for (int j = 0; j < 8; j++) begin
         RX = b[j];
         tick(BD);
      end
      RX = stopBit;
      tick(BD);
      RX = 1'b1;
      tick(BD);
   endtask

   task automatic waitNotBusy(input int limit, output bit timedOut);
      timedOut = 1'b1;
      for (int i = 0; i < limit; i++) begin
         if (busy === 1'b0) begin
            timedOut = 1'b0;
            break;
         end
         tick(1);
      end
   endtask

   // Called right after the accepting edge; covers every clock of the frame.
   task automatic checkFrame(input logic [7:0] c, input logic [15:0] d, input string name);
      logic [29:0] bits;
      logic [7:0]  frameBytes [3];
      int          firstBad;
      logic        gotTx;
      logic        gotBusy;
      frameBytes = '{c, d[15:8], d[7:0]};
      for (int k = 0; k < 3; k++) begin
         bits[k*10] = 1'b0;
         for (int j = 0; j < 8; j++) bits[k*10+1+j] = frameBytes[k][j];
         bits[k*10+9] = 1'b1;
      end
      firstBad = -1;
      gotTx = 1'b0;
      gotBusy = 1'b0;
      for (int cyc = 0; cyc < FRAME; cyc++) begin
         if (cyc != 0) tick(1);
         if (firstBad < 0 && (TX !== bits[cyc/BD] || busy !== 1'b1)) begin
            firstBad = cyc;
            gotTx = TX;
            gotBusy = busy;
         end
      end
      testsRun++;
      if (firstBad >= 0) begin
         testsFailed++;
         $display("[TB] FAIL %s: cycle %0d got TX=%b busy=%b, expected TX=%b busy=1",
                  name, firstBad, gotTx, gotBusy, bits[firstBad/BD]);
      end
   endtask

   task automatic checkReply(input logic [7:0] b, input int rdyBefore, input string name);
      bit timedOut;
      waitNotBusy(300, timedOut);
      tick(2);
      testsRun++;
      if (timedOut !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL %s_done: busy still high after reply, expected busy=0", name);
      end
      testsRun++;
      if (resp !== b) begin
         testsFailed++;
         $display("[TB] FAIL %s_resp: got %h, expected %h", name, resp, b);
      end
      testsRun++;
      if (rdyPulses - rdyBefore !== 1) begin
         testsFailed++;
         $display("[TB] FAIL %s_rdy: got %0d pulses, expected 1", name, rdyPulses - rdyBefore);
      end
      testsRun++;
      if (cmd_cmplt !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL %s_cmplt: got %b, expected 1", name, cmd_cmplt);
      end
      expResp = b;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick(2);
      testsRun++; if (TX !== 1'b1)        begin testsFailed++; $display("[TB] FAIL reset_tx: got %b, expected 1", TX); end
      testsRun++; if (busy !== 1'b0)      begin testsFailed++; $display("[TB] FAIL reset_busy: got %b, expected 0", busy); end
      testsRun++; if (resp !== 8'h00)     begin testsFailed++; $display("[TB] FAIL reset_resp: got %h, expected 00", resp); end
      testsRun++; if (resp_rdy !== 1'b0)  begin testsFailed++; $display("[TB] FAIL reset_rdy: got %b, expected 0", resp_rdy); end
      testsRun++; if (cmd_cmplt !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_cmplt: got %b, expected 0", cmd_cmplt); end
      testsRun++; if (tmo !== 1'b0)       begin testsFailed++; $display("[TB] FAIL reset_tmo: got %b, expected 0", tmo); end
      rst = 1'b0;
      expResp = 8'h00;
      tick(2);
   endtask

   task automatic test_loopback(input logic [7:0] c, input logic [15:0] d, input logic [7:0] b, input string name);
      int rdyBefore;
      sendCmd(c, d);
      testsRun++;
      if (cmd_cmplt !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL %s_cmplt_clear: got %b, expected 0", name, cmd_cmplt);
      end
      checkFrame(c, d, name);
      rdyBefore = rdyPulses;
      sendRx(b, 1'b1);
      checkReply(b, rdyBefore, name);
   endtask

   task automatic test_ignore_busy;
      logic [7:0] b;
      int rdyBefore;
      b = 8'($urandom);
      sendCmd(8'h02, 16'h1234);
      fork
         checkFrame(8'h02, 16'h1234, "ignore_frame");
         begin
            tick(99);
            cmd = 8'hFF;
            data = 16'hBEEF;
            snd_cmd = 1'b1;
            tick(1);
            snd_cmd = 1'b0;
         end
      join
      rdyBefore = rdyPulses;
      sendRx(b, 1'b1);
      checkReply(b, rdyBefore, "ignore");
   endtask

   task automatic test_framing_error;
      logic [7:0] bad;
      logic [7:0] good;
      int rdyBefore;
      logic [7:0] c;
      logic [15:0] d;
      bad = 8'($urandom);
      good = 8'($urandom);
      c = 8'($urandom);
      d = 16'($urandom);
      sendCmd(c, d);
      checkFrame(c, d, "framing_frame");
      rdyBefore = rdyPulses;
      sendRx(bad, 1'b0);
      tick(4);
      testsRun++; if (rdyPulses != rdyBefore) begin testsFailed++; $display("[TB] FAIL framing_rdy: got %0d pulses, expected 0", rdyPulses - rdyBefore); end
      testsRun++; if (resp !== expResp)       begin testsFailed++; $display("[TB] FAIL framing_resp: got %h, expected %h", resp, expResp); end
      testsRun++; if (busy !== 1'b1)          begin testsFailed++; $display("[TB] FAIL framing_busy: got %b, expected 1", busy); end
      rdyBefore = rdyPulses;
      sendRx(good, 1'b1);
      checkReply(good, rdyBefore, "framing_recover");
   endtask

   task automatic test_discard_during_frame;
      logic [7:0] early;
      logic [7:0] good;
      int rdyBefore;
      early = 8'($urandom);
      good = 8'($urandom);
      rdyBefore = rdyPulses;
      sendCmd(8'h5A, 16'hC3E1);
      fork
         checkFrame(8'h5A, 16'hC3E1, "discard_frame");
         begin
            tick(10);
            sendRx(early, 1'b1);
         end
      join
      tick(1);
      testsRun++; if (rdyPulses != rdyBefore) begin testsFailed++; $display("[TB] FAIL discard_rdy: got %0d pulses, expected 0", rdyPulses - rdyBefore); end
      testsRun++; if (resp !== expResp)       begin testsFailed++; $display("[TB] FAIL discard_resp: got %h, expected %h", resp, expResp); end
      testsRun++; if (busy !== 1'b1)          begin testsFailed++; $display("[TB] FAIL discard_busy: got %b, expected 1", busy); end
      rdyBefore = rdyPulses;
      sendRx(good, 1'b1);
      checkReply(good, rdyBefore, "discard_recover");
   endtask

   task automatic test_early_reply;
      logic [7:0] b;
      logic [7:0] c;
      logic [15:0] d;
      int rdyBefore;
      b = 8'($urandom);
      c = 8'($urandom);
      d = 16'($urandom);
      rdyBefore = rdyPulses;
      sendCmd(c, d);
      fork
         checkFrame(c, d, "early_frame");
         begin
            tick(400);
            sendRx(b, 1'b1);
         end
      join
      checkReply(b, rdyBefore, "early");
   endtask

   task automatic test_idle_discard;
      logic [7:0] b;
      int rdyBefore;
      b = ~expResp;
      rdyBefore = rdyPulses;
      sendRx(b, 1'b1);
      tick(2);
      testsRun++; if (rdyPulses != rdyBefore) begin testsFailed++; $display("[TB] FAIL idle_rdy: got %0d pulses, expected 0", rdyPulses - rdyBefore); end
      testsRun++; if (resp !== expResp)       begin testsFailed++; $display("[TB] FAIL idle_resp: got %h, expected %h", resp, expResp); end
      testsRun++; if (busy !== 1'b0)          begin testsFailed++; $display("[TB] FAIL idle_busy: got %b, expected 0", busy); end
   endtask

   task automatic test_reset_mid_frame;
      sendCmd(8'h02, 16'h1234);
      tick(199);
      rst = 1'b1;
      snd_cmd = 1'b1;
      tick(1);
      testsRun++; if (TX !== 1'b1)        begin testsFailed++; $display("[TB] FAIL midreset_tx: got %b, expected 1", TX); end
      testsRun++; if (busy !== 1'b0)      begin testsFailed++; $display("[TB] FAIL midreset_busy: got %b, expected 0", busy); end
      testsRun++; if (resp !== 8'h00)     begin testsFailed++; $display("[TB] FAIL midreset_resp: got %h, expected 00", resp); end
      testsRun++; if (cmd_cmplt !== 1'b0) begin testsFailed++; $display("[TB] FAIL midreset_cmplt: got %b, expected 0", cmd_cmplt); end
      tick(1);
      testsRun++; if (busy !== 1'b0)      begin testsFailed++; $display("[TB] FAIL reset_priority: got busy=%b, expected 0", busy); end
      snd_cmd = 1'b0;
      rst = 1'b0;
      expResp = 8'h00;
      tick(1);
      test_loopback(8'($urandom), 16'($urandom), 8'($urandom), "after_reset");
   endtask

   task automatic test_timeout;
      int firstTmo;
      int tmoBefore;
      logic [7:0] c;
      logic [15:0] d;
      c = 8'($urandom);
      d = 16'($urandom);
      tmoBefore = tmoPulses;
      sendCmd(c, d);
      checkFrame(c, d, "tmo_frame");
      firstTmo = -1;
      for (int k = 1; k <= TMO + 100; k++) begin
         tick(1);
         if (firstTmo < 0 && tmo === 1'b1) firstTmo = k;
      end
`ifdef COMM_MASTER_TMO_EN
      testsRun++; if (firstTmo != TMO + 1)          begin testsFailed++; $display("[TB] FAIL tmo_time: got cycle %0d, expected %0d", firstTmo, TMO + 1); end
      testsRun++; if (tmoPulses - tmoBefore != 1)   begin testsFailed++; $display("[TB] FAIL tmo_pulses: got %0d, expected 1", tmoPulses - tmoBefore); end
      testsRun++; if (busy !== 1'b0)                begin testsFailed++; $display("[TB] FAIL tmo_busy: got %b, expected 0", busy); end
      testsRun++; if (cmd_cmplt !== 1'b0)           begin testsFailed++; $display("[TB] FAIL tmo_cmplt: got %b, expected 0", cmd_cmplt); end
`else
      testsRun++; if (tmoPulses != tmoBefore)       begin testsFailed++; $display("[TB] FAIL tmo_never: got %0d pulses at cycle %0d, expected 0", tmoPulses - tmoBefore, firstTmo); end
      testsRun++; if (busy !== 1'b1)                begin testsFailed++; $display("[TB] FAIL tmo_wait_busy: got %b, expected 1", busy); end
`endif
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      expResp = 8'h00;
      tick(1);
   endtask

   initial begin
      test_reset();
      test_loopback(8'h02, 16'h1234, 8'hA5, "basic");
      for (int i = 0; i < 3; i++) begin
         test_loopback(8'($urandom), 16'($urandom), 8'($urandom), "random");
      end
      test_ignore_busy();
      test_framing_error();
      test_discard_during_frame();
      test_early_reply();
      test_idle_discard();
      test_reset_mid_frame();
      test_timeout();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
